// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution block.
package branch_pkg;

  // ARMv8 condition field encodings
  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, HS = 4'h2, LO = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_code_t;

  // Branch flavour carried with each request
  typedef enum logic [1:0] {
    OP_B     = 2'b00,
    OP_BCOND = 2'b01,
    OP_CBZ   = 2'b10,
    OP_CBNZ  = 2'b11
  } cond_op_t;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARMv8 condition-code evaluator over an NZCV vector.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0]  nzcv,
  input  cond_code_t  cond_code,
  output logic        cond_true
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;

  assign n_flag = nzcv[FLAG_N];
  assign z_flag = nzcv[FLAG_Z];
  assign c_flag = nzcv[FLAG_C];
  assign v_flag = nzcv[FLAG_V];

  // Full 16-entry condition table; NV behaves as always-true on ARMv8
  always_comb begin
    cond_true = 1'b0;
    case (cond_code)
      EQ: cond_true = z_flag;
      NE: cond_true = ~z_flag;
      HS: cond_true = c_flag;
      LO: cond_true = ~c_flag;
      MI: cond_true = n_flag;
      PL: cond_true = ~n_flag;
      VS: cond_true = v_flag;
      VC: cond_true = ~v_flag;
      HI: cond_true = c_flag & ~z_flag;
      LS: cond_true = ~(c_flag & ~z_flag);
      GE: cond_true = (n_flag == v_flag);
      LT: cond_true = (n_flag != v_flag);
      GT: cond_true = ~z_flag & (n_flag == v_flag);
      LE: cond_true = ~(~z_flag & (n_flag == v_flag));
      AL: cond_true = 1'b1;
      NV: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: NZCV register with forwarding, branch decision into
// MEM with stall/flush, and saturating branch statistics counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int N       = 64,
  parameter int REG_OUT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic [3:0]       alu_flags_in,
  input  logic             cond_valid,
  input  logic [1:0]       cond_op,
  input  logic [3:0]       cond_code,
  input  logic [N-1:0]     cb_operand,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       flags_q,
  output logic             branch_valid,
  output logic             take_branch,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_taken
);

  logic [3:0]       flags_d;
  logic [3:0]       fwd_flags;
  cond_op_t         op;
  logic             cond_true;
  logic             taken;
  logic             accept;
  logic [CNT_W-1:0] cnt_branches_q;
  logic [CNT_W-1:0] cnt_branches_d;
  logic [CNT_W-1:0] cnt_taken_q;
  logic [CNT_W-1:0] cnt_taken_d;

  // A flag write in flight this cycle is visible to a dependent B.cond
  assign fwd_flags = flag_we ? alu_flags_in : flags_q;
  assign op        = cond_op_t'(cond_op);

  cond_eval u_cond_eval (
    .nzcv      (fwd_flags),
    .cond_code (cond_code_t'(cond_code)),
    .cond_true (cond_true)
  );

  // Resolve the branch direction for the current request
  always_comb begin
    taken = 1'b0;
    case (op)
      OP_B:     taken = 1'b1;
      OP_BCOND: taken = cond_true;
      OP_CBZ:   taken = (cb_operand == '0);
      OP_CBNZ:  taken = (cb_operand != '0);
      default:  taken = 1'b0;
    endcase
  end

  assign accept = cond_valid & ~stall & ~flush;

  // Flag writes belong to an older instruction, so flush does not block them
  always_comb begin
    flags_d = flags_q;
    if (flag_we && !stall) begin
      flags_d = alu_flags_in;
    end
  end

  // Saturating statistics: counters stick at all-ones instead of wrapping
  always_comb begin
    cnt_branches_d = cnt_branches_q;
    cnt_taken_d    = cnt_taken_q;
    if (accept) begin
      if (cnt_branches_q != '1) begin
        cnt_branches_d = cnt_branches_q + CNT_W'(1);
      end
      if (taken && (cnt_taken_q != '1)) begin
        cnt_taken_d = cnt_taken_q + CNT_W'(1);
      end
    end
  end

  // Architectural flags and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q        <= 4'b0000;
      cnt_branches_q <= '0;
      cnt_taken_q    <= '0;
    end else begin
      flags_q        <= flags_d;
      cnt_branches_q <= cnt_branches_d;
      cnt_taken_q    <= cnt_taken_d;
    end
  end

  assign cnt_branches = cnt_branches_q;
  assign cnt_taken    = cnt_taken_q;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic valid_q;
      logic valid_d;
      logic take_q;
      logic take_d;

      // Next decision: flush kills, stall holds, otherwise capture the request
      always_comb begin
        valid_d = valid_q;
        take_d  = take_q;
        if (flush) begin
          valid_d = 1'b0;
          take_d  = 1'b0;
        end else if (!stall) begin
          valid_d = cond_valid;
          take_d  = cond_valid & taken;
        end
      end

      // Decision register feeding the MEM stage
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q <= 1'b0;
          take_q  <= 1'b0;
        end else begin
          valid_q <= valid_d;
          take_q  <= take_d;
        end
      end

      assign branch_valid = valid_q;
      assign take_branch  = take_q;
    end else begin : g_comb_out
      // Zero-latency path; the downstream stage is responsible for holding on stall
      assign branch_valid = cond_valid & ~flush;
      assign take_branch  = cond_valid & ~flush & taken;
    end
  endgenerate

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: registered and combinational instances
// driven in parallel, checked against a behavioural model every cycle plus
// directed literal expectations.
module tb_branch_resolve_unit;

  localparam int NW  = 64;
  localparam int CW  = 4;
  localparam int CMX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          flag_we;
  logic [3:0]    alu_flags_in;
  logic          cond_valid;
  logic [1:0]    cond_op;
  logic [3:0]    cond_code;
  logic [NW-1:0] cb_operand;
  logic          stall;
  logic          flush;

  logic [3:0]    r_flags, c_flags;
  logic          r_bv, r_tb, c_bv, c_tb;
  logic [CW-1:0] r_cb, r_ct, c_cb, c_ct;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // model state
  logic [3:0] m_flags = 4'b0;
  logic       m_bv = 1'b0;
  logic       m_tb = 1'b0;
  int         m_cb = 0;
  int         m_ct = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.N(NW), .REG_OUT(1), .CNT_W(CW)) u_reg (
    .clk(clk), .reset(reset), .flag_we(flag_we), .alu_flags_in(alu_flags_in),
    .cond_valid(cond_valid), .cond_op(cond_op), .cond_code(cond_code),
    .cb_operand(cb_operand), .stall(stall), .flush(flush),
    .flags_q(r_flags), .branch_valid(r_bv), .take_branch(r_tb),
    .cnt_branches(r_cb), .cnt_taken(r_ct)
  );

  branch_resolve_unit #(.N(NW), .REG_OUT(0), .CNT_W(CW)) u_comb (
    .clk(clk), .reset(reset), .flag_we(flag_we), .alu_flags_in(alu_flags_in),
    .cond_valid(cond_valid), .cond_op(cond_op), .cond_code(cond_code),
    .cb_operand(cb_operand), .stall(stall), .flush(flush),
    .flags_q(c_flags), .branch_valid(c_bv), .take_branch(c_tb),
    .cnt_branches(c_cb), .cnt_taken(c_ct)
  );

  // ARM pseudocode style: base condition from code[3:1], inverted by code[0] except 1111
  function automatic logic model_taken(input logic [1:0] op, input logic [3:0] code,
                                       input logic [3:0] f, input logic [NW-1:0] opnd);
    logic n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (op == 2'b00) return 1'b1;
    if (op == 2'b10) return (opnd == 0);
    if (op == 2'b11) return (opnd != 0);
    case (code[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (code[0] && code != 4'hF) r = !r;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // behavioural model of the architectural state
  always @(posedge clk) begin
    logic [3:0] f;
    logic tk;
    f  = flag_we ? alu_flags_in : m_flags;
    tk = model_taken(cond_op, cond_code, f, cb_operand);
    if (reset) begin
      m_flags <= 4'b0; m_bv <= 1'b0; m_tb <= 1'b0; m_cb <= 0; m_ct <= 0;
    end else begin
      if (flag_we && !stall) m_flags <= alu_flags_in;
      if (flush) begin
        m_bv <= 1'b0; m_tb <= 1'b0;
      end else if (!stall) begin
        m_bv <= cond_valid; m_tb <= cond_valid && tk;
      end
      if (cond_valid && !stall && !flush) begin
        if (m_cb < CMX) m_cb <= m_cb + 1;
        if (tk && m_ct < CMX) m_ct <= m_ct + 1;
      end
    end
  end

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    logic e_bv, e_tb;
    if (chk_en) begin
      e_bv = cond_valid && !flush;
      e_tb = e_bv && model_taken(cond_op, cond_code, flag_we ? alu_flags_in : m_flags, cb_operand);
      chk("reg.flags", r_flags, m_flags);
      chk("reg.valid", r_bv, m_bv);
      chk("reg.take", r_tb, m_tb);
      chk("reg.cnt_br", r_cb, m_cb);
      chk("reg.cnt_tk", r_ct, m_ct);
      chk("comb.flags", c_flags, m_flags);
      chk("comb.valid", c_bv, e_bv);
      chk("comb.take", c_tb, e_tb);
      chk("comb.cnt_br", c_cb, m_cb);
      chk("comb.cnt_tk", c_ct, m_ct);
    end
  end

  logic [15:0]   exp_sweep = 16'b1101_0110_0101_1010;
  logic [1:0]    cb_ops [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
  logic [NW-1:0] cb_vals[4] = '{64'h0, 64'h8000_0000_0000_0000, 64'h0, 64'h8000_0000_0000_0000};
  logic          cb_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; flag_we = 1'b0; alu_flags_in = 4'b0; cond_valid = 1'b0;
    cond_op = 2'b00; cond_code = 4'b0; cb_operand = '0; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst.valid", r_bv, 1'b0);
    chk("rst.take", r_tb, 1'b0);
    chk("rst.flags", r_flags, 4'b0);
    chk("rst.cnt_br", r_cb, 0);

    // same-cycle flag write feeding B.EQ
    reset = 1'b0;
    flag_we = 1'b1; alu_flags_in = 4'b0100; cond_valid = 1'b1; cond_op = 2'b01; cond_code = 4'b0000;
    #1;
    chk("fwd.comb_take", c_tb, 1'b1);
    tick();
    chk("fwd.valid", r_bv, 1'b1);
    chk("fwd.take", r_tb, 1'b1);
    chk("fwd.flags", r_flags, 4'b0100);

    // load N=1,V=1 then sweep all condition codes
    alu_flags_in = 4'b1001; cond_valid = 1'b0;
    tick();
    flag_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cond_valid = 1'b1; cond_op = 2'b01; cond_code = 4'(i);
      #1;
      chk($sformatf("sweep.comb_take[%0d]", i), c_tb, exp_sweep[i]);
      tick();
      chk($sformatf("sweep.valid[%0d]", i), r_bv, 1'b1);
      chk($sformatf("sweep.take[%0d]", i), r_tb, exp_sweep[i]);
    end

    // CBZ / CBNZ
    for (int i = 0; i < 4; i++) begin
      cond_op = cb_ops[i]; cb_operand = cb_vals[i];
      tick();
      chk($sformatf("cb.take[%0d]", i), r_tb, cb_exp[i]);
    end

    // stall and flush
    cond_valid = 1'b0; cb_operand = '0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2.cnt_br", r_cb, 0);
    cond_valid = 1'b1; cond_op = 2'b01; cond_code = 4'b0000;
    tick();
    chk("nt.take", r_tb, 1'b0);
    chk("nt.cnt_br", r_cb, 1);
    chk("nt.cnt_tk", r_ct, 0);
    cond_op = 2'b00;
    tick();
    chk("b.take", r_tb, 1'b1);
    chk("b.cnt_br", r_cb, 2);
    chk("b.cnt_tk", r_ct, 1);
    stall = 1'b1; flag_we = 1'b1; alu_flags_in = 4'b1111; cond_op = 2'b01; cond_code = 4'b0001;
    #1;
    chk("stall.comb_take", c_tb, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall.valid[%0d]", i), r_bv, 1'b1);
      chk($sformatf("stall.take[%0d]", i), r_tb, 1'b1);
      chk($sformatf("stall.flags[%0d]", i), r_flags, 4'b0000);
      chk($sformatf("stall.cnt_br[%0d]", i), r_cb, 2);
      chk($sformatf("stall.cnt_tk[%0d]", i), r_ct, 1);
    end
    stall = 1'b0; flush = 1'b1; alu_flags_in = 4'b0010;
    #1;
    chk("flush.comb_valid", c_bv, 1'b0);
    tick();
    chk("flush.valid", r_bv, 1'b0);
    chk("flush.take", r_tb, 1'b0);
    chk("flush.flags", r_flags, 4'b0010);
    chk("flush.cnt_br", r_cb, 2);
    chk("flush.cnt_tk", r_ct, 1);
    flush = 1'b0; flag_we = 1'b0; cond_valid = 1'b0;

    // saturation with 4-bit counters
    reset = 1'b1; tick(); reset = 1'b0;
    cond_valid = 1'b1; cond_op = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13) chk("sat.cnt_br_14", r_cb, 14);
    end
    chk("sat.cnt_br", r_cb, 15);
    chk("sat.cnt_tk", r_ct, 15);
    chk("sat.comb_cnt_tk", c_ct, 15);

    // reset in the middle of a burst
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("burst.cnt_br", r_cb, 5);
    reset = 1'b1;
    tick();
    chk("midrst.valid", r_bv, 1'b0);
    chk("midrst.take", r_tb, 1'b0);
    chk("midrst.flags", r_flags, 4'b0);
    chk("midrst.cnt_br", r_cb, 0);
    chk("midrst.cnt_tk", r_ct, 0);
    reset = 1'b0; cond_valid = 1'b0;
    tick(); tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor to the single-cycle branch-condition checker. It holds the architectural NZCV flag register and forwards same-cycle flag writes. It evaluates all 16 ARMv8 condition codes plus CBZ/CBNZ on an N-bit operand, and registers the branch decision into the MEM stage with stall/flush control. It also keeps saturating branch statistics counters for the performance-counter block.

Parameters:
N, 64, width of the CBZ/CBNZ operand
REG_OUT, 1, 1 = decision registered (latency 1); 0 = combinational (latency 0)
CNT_W, 32, width of each statistics counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
flag_we  input  1  older flag-setting instruction (ADDS/SUBS/ANDS) writes NZCV this cycle
alu_flags_in  input  4  {N,Z,C,V} from the ALU
cond_valid  input  1  branch request present this cycle
cond_op  input  2  00 B (unconditional), 01 B.cond, 10 CBZ, 11 CBNZ
cond_code  input  4  ARMv8 cond field, used only when cond_op=01
cb_operand  input  N  Rt value for CBZ/CBNZ
stall  input  1  freeze: hold all state
flush  input  1  kill the request in flight and the pending output
flags_q  output  4  architectural NZCV register
branch_valid  output  1  decision valid
take_branch  output  1  branch taken (meaningful only when branch_valid=1)
cnt_branches  output  CNT_W  accepted branch requests
cnt_taken  output  CNT_W  accepted requests resolved taken

Behaviour:
- Reset (synchronous, reset=1 at a clk edge): flags_q=0, branch_valid=0, take_branch=0, both counters=0. Reset overrides stall, flush and every other input.
- Flag register: on a clk edge with flag_we=1 and stall=0, flags_q <= alu_flags_in. Otherwise it holds.
- Forwarding: f = flag_we ? alu_flags_in : flags_q. All condition evaluation uses f, so a flag write and a dependent B.cond in the same cycle see the new flags.
- Condition table (f={N,Z,C,V}):
  - 0000 EQ: Z; 0001 NE: !Z
  - 0010 HS: C; 0011 LO: !C
  - 0100 MI: N; 0101 PL: !N
  - 0110 VS: V; 0111 VC: !V
  - 1000 HI: C&!Z; 1001 LS: !(C&!Z)
  - 1010 GE: N==V; 1011 LT: N!=V
  - 1100 GT: !Z&(N==V); 1101 LE: !(!Z&(N==V))
  - 1110 AL: 1; 1111 NV: 1 (ARMv8 treats NV as always)
- Decision: cond_op 00 -> taken=1; 01 -> table result; 10 -> (cb_operand==0); 11 -> (cb_operand!=0).
- Accept = cond_valid & !stall & !flush.
- REG_OUT=1, priority at each clk edge is reset > flush > stall > normal:
  - flush: branch_valid<=0, take_branch<=0.
  - stall: outputs hold.
  - normal: branch_valid<=cond_valid, take_branch<=cond_valid & taken.
- REG_OUT=0: branch_valid = cond_valid & !flush; take_branch = branch_valid & taken, both combinational. With stall=1 the outputs still reflect the inputs; the downstream stage holds them.
- take_branch is never 1 while branch_valid is 0.
- Counters: on accept, cnt_branches+=1, and cnt_taken+=1 if taken. Both saturate at 2^CNT_W-1 and never wrap. Neither changes on stall or flush.
- Stall and flag_we together: no flag write. Upstream keeps flag_we asserted until the stall is released.
- A flush in the same cycle as a new request drops the request. If flag_we=1 that cycle, the flag write still occurs unless stall=1, because it belongs to an older instruction.

Decomposition:
- Package branch_pkg:
  - enum cond_code_t (EQ..NV, 4 bits)
  - enum cond_op_t (OP_B, OP_BCOND, OP_CBZ, OP_CBNZ)
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- Sub-module cond_eval: purely combinational; inputs nzcv[3:0] and cond_code_t; output cond_true. The top level instantiates it once and owns all sequential state.

Test Plan:
- Reset, then flag_we=1, alu_flags_in=0100, cond_valid=1, op=01, code=0000 in the same cycle -> next cycle branch_valid=1, take_branch=1 (EQ via forwarding), flags_q=0100.
- flags_q=1001 (N=1,V=1), sweep codes 0000..1111 with REG_OUT=1 -> take_branch sequence 0,1,0,1,1,0,1,0,0,1,1,0,1,0,1,1, each valid one cycle after issue.
- op=10 with cb_operand=0 -> taken=1; cb_operand=64'h8000_0000_0000_0000 -> taken=0; op=11 on the same two values -> 0 then 1.
- Request with stall=1 for 3 cycles, then flush=1 -> outputs hold their prior values during the stall, then branch_valid=0; counters unchanged; flags_q unchanged despite flag_we=1 during the stall.
- CNT_W=4: 20 accepted taken B requests -> cnt_branches=cnt_taken=15 (saturated); assert reset mid-burst -> all outputs 0 on the next edge.
